// File: rtl/svc_rv_mem_arb.sv
// svc_rv_mem_arb: shares one SRAM/BRAM port between instruction fetch and
// data access. Data wins; a losing fetch is held pending and replayed.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   imem_arvalid/araddr            fetch request (byte address)
//   imem_rvalid/rdata              fetch response (rdata holds when !rvalid)
//   dmem_ren/raddr, dmem_rdata     load request / load data
//   dmem_we/waddr/wdata/wstrb      store request
//   dmem_stall                     core must hold dmem_* next cycle
//   mem_ren/we/addr/wdata/wstrb    shared memory port (word address)
//   mem_rdata                      shared read data, timing per MEM_TYPE
//
// Parameters: AW (word address width), MEM_TYPE (0 SRAM, 1 BRAM),
// STARVE_MAX (fetch starvation limit).
// Optional macro SVC_RV_MEM_ARB_STARVE_EN: force a fetch grant after
// STARVE_MAX consecutive lost cycles.

module svc_rv_mem_arb #(
   parameter int unsigned AW         = 10,
   parameter int unsigned MEM_TYPE   = 0,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          imem_arvalid,
   input  logic [31:0]   imem_araddr,
   output logic [31:0]   imem_rdata,
   output logic          imem_rvalid,
   input  logic          dmem_ren,
   input  logic [31:0]   dmem_raddr,
   output logic [31:0]   dmem_rdata,
   input  logic          dmem_we,
   input  logic [31:0]   dmem_waddr,
   input  logic [31:0]   dmem_wdata,
   input  logic [3:0]    dmem_wstrb,
   output logic          dmem_stall,
   output logic          mem_ren,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   output logic [3:0]    mem_wstrb,
   input  logic [31:0]   mem_rdata
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {IDLE, STORE_FIRST, FETCH_PEND} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} owner_t;

   state_t        state;
   logic          wr_done;
   logic          pend_valid;
   logic [AW-1:0] pend_addr;
   logic [31:0]   imem_hold;
   logic [31:0]   dmem_hold;

   logic          store_req, load_req, fetch_req, force_fetch;
   logic          do_store, do_load, do_fetch, fetch_lost;
   logic [AW-1:0] fetch_addr;
   logic          unused_addr;

   // A store already issued while its paired load waits must not repeat
   assign wr_done = (state == STORE_FIRST);

   // Newest fetch address wins over a pending one (redirect/flush)
   assign fetch_addr = imem_arvalid ? imem_araddr[AW+1:2] : pend_addr;

   // All requests are masked during reset so the port stays quiet
   assign store_req = rst_n && dmem_we && !wr_done;
   assign load_req  = rst_n && dmem_ren;
   assign fetch_req = rst_n && (imem_arvalid || pend_valid);

`ifdef SVC_RV_MEM_ARB_STARVE_EN
   localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   logic [SW-1:0] starve_cnt;

   assign force_fetch = fetch_req && (starve_cnt == SW'(STARVE_MAX));

   // Saturating count of consecutive lost fetch cycles
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (do_fetch) begin
         starve_cnt <= '0;
      end else if (fetch_lost && (starve_cnt != SW'(STARVE_MAX))) begin
         starve_cnt <= starve_cnt + SW'(1);
      end
   end
`else
   logic unused_starve;
   assign force_fetch   = 1'b0;
   assign unused_starve = (STARVE_MAX != 0);
`endif

   // Priority: store, load, fetch (pending or new); a forced fetch preempts data
   assign do_store   = store_req && !force_fetch;
   assign do_load    = load_req && !store_req && !force_fetch;
   assign do_fetch   = fetch_req && (force_fetch || (!store_req && !load_req));
   assign fetch_lost = fetch_req && !do_fetch;

   // Stall when a load is owed behind a store, or data was preempted by a fetch
   assign dmem_stall = (store_req && load_req) ||
                       (force_fetch && (store_req || load_req));

   assign mem_ren   = do_load || do_fetch;
   assign mem_we    = do_store;
   assign mem_addr  = do_store ? dmem_waddr[AW+1:2] :
                      do_load  ? dmem_raddr[AW+1:2] :
                      do_fetch ? fetch_addr : '0;
   assign mem_wdata = dmem_wdata;
   assign mem_wstrb = do_store ? dmem_wstrb : 4'h0;

   // Arbitration state, pending fetch and response hold registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         pend_valid <= 1'b0;
         pend_addr  <= '0;
         imem_hold  <= NOP;
         dmem_hold  <= '0;
      end else begin
         if (dmem_stall && dmem_we && (wr_done || do_store)) begin
            state <= STORE_FIRST;
         end else if (fetch_lost) begin
            state <= FETCH_PEND;
         end else begin
            state <= IDLE;
         end

         if (do_fetch) begin
            pend_valid <= 1'b0;
         end else if (fetch_lost) begin
            pend_valid <= 1'b1;
            pend_addr  <= fetch_addr;
         end

         imem_hold <= imem_rdata;
         dmem_hold <= dmem_rdata;
      end
   end

   generate
      if (MEM_TYPE == 0) begin : g_sram
         // Combinational read: data returns in the grant cycle
         assign imem_rvalid = do_fetch;
         assign imem_rdata  = do_fetch ? mem_rdata : imem_hold;
         assign dmem_rdata  = do_load  ? mem_rdata : dmem_hold;
      end else begin : g_bram
         owner_t owner;

         // Owner tag routes the registered read data one cycle after grant
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               owner <= OWN_NONE;
            end else if (do_fetch) begin
               owner <= OWN_FETCH;
            end else if (do_load) begin
               owner <= OWN_DATA;
            end else begin
               owner <= OWN_NONE;
            end
         end

         assign imem_rvalid = (owner == OWN_FETCH);
         assign imem_rdata  = (owner == OWN_FETCH) ? mem_rdata : imem_hold;
         assign dmem_rdata  = (owner == OWN_DATA)  ? mem_rdata : dmem_hold;
      end
   endgenerate

   // Bits outside the word address window are ignored (addresses wrap)
   assign unused_addr = ^{imem_araddr[31:AW+2], imem_araddr[1:0],
                          dmem_raddr[31:AW+2],  dmem_raddr[1:0],
                          dmem_waddr[31:AW+2],  dmem_waddr[1:0]};

endmodule
